irq_ctrl: RTL and testbench

Interrupt controller between the memory-mapped peripherals (timers, UART, switches) and the CPU's exception logic. Collects up to `N_SRC` device IRQ lines into a pending register, applies a mask and a global enable, and selects the highest-priority active source. It raises a single registered interrupt request to the CPU and runs an acknowledge/return handshake so that nested requests stay blocked until the handler returns. The block is also a bus slave on the same 2-bit word-address register interface as the timers, so software can read and clear state.

---
 rtl/irq_ctrl_pkg.sv | 15 +
 rtl/irq_ctrl_if.sv | 12 +
 rtl/irq_ctrl_prio_enc.sv | 14 +
 rtl/irq_ctrl.sv | 82 ++++++++
 tb/tb_irq_ctrl.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg: register map, one-hot FSM encoding and STATUS bit positions
// shared by the interrupt controller files.
package irq_ctrl_pkg;
    localparam logic [1:0] REG_MASK   = 2'd0;
    localparam logic [1:0] REG_PEND   = 2'd1;
    localparam logic [1:0] REG_CAUSE  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;
    typedef enum logic [2:0] {
        IDLE    = 3'b001,
        REQ     = 3'b010,
        SERVICE = 3'b100
    } state_t;
    localparam int STAT_IE  = 0;
    localparam int STAT_EXL = 1;
endpackage

// File: rtl/irq_ctrl_if.sv
// irq_ctrl_if: register bus plus the CPU request/acknowledge/return handshake.
interface irq_ctrl_if;
    logic [3:2]  addr;
    logic        We;
    logic [31:0] Datain;
    logic [31:0] Dataout;
    logic        IntReq;
    logic        IntAck;
    logic        Eret;
    modport master (output addr, We, Datain, IntAck, Eret, input Dataout, IntReq);
    modport slave  (input addr, We, Datain, IntAck, Eret, output Dataout, IntReq);
endinterface

// File: rtl/irq_ctrl_prio_enc.sv
// irq_prio_enc: lowest-index-wins priority encoder producing {any, id}.
module irq_prio_enc #(
    parameter int N = 6
) (
    input  logic [N-1:0] req,
    output logic         any,
    output logic [2:0]   id
);
    always_comb begin
        any = |req;
        id  = '0;
        for (int i = N - 1; i >= 0; i--) id = req[i] ? i[2:0] : id;
    end
endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: pending/mask/enable interrupt controller with CPU ack/return handshake.
// Define IRQ_EDGE_DETECT_EN for rising-edge pending; default is level-sensitive.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int N_SRC = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] HWInt,
    irq_ctrl_if.slave        bus
);
    state_t             state_q, state_d;
    logic [N_SRC-1:0]   mask_q, mask_d, pend_q, pend_d, active, set_v;
    logic               ie_q, ie_d, cv_q, cv_d;
    logic [2:0]         cid_q, cid_d, id;
    logic               any, exl, fire, ack_in_req;

`ifdef IRQ_EDGE_DETECT_EN
    logic [N_SRC-1:0] prev_q;
    always_ff @(posedge clk) prev_q <= reset ? '0 : HWInt;
    assign set_v = HWInt & ~prev_q;
`else
    assign set_v = HWInt;
`endif

    assign active     = pend_q & mask_q;
    assign exl        = state_q == SERVICE;
    assign fire       = any & ie_q & ~exl;
    assign ack_in_req = state_q == REQ && bus.IntAck;

    irq_prio_enc #(.N(N_SRC)) u_enc (.req(active), .any(any), .id(id));

    // A new event outranks a W1C of the same bit, so the set is OR'd in last.
    always_comb begin
        mask_d = (bus.We && bus.addr == REG_MASK) ? bus.Datain[N_SRC-1:0] : mask_q;
        pend_d = (pend_q & ~((bus.We && bus.addr == REG_PEND) ? bus.Datain[N_SRC-1:0] : '0)) | set_v;
        ie_d   = (bus.We && bus.addr == REG_STATUS) ? bus.Datain[STAT_IE] : ie_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            mask_q  <= '0;
            pend_q  <= '0;
            ie_q    <= 1'b0;
            cv_q    <= 1'b0;
            cid_q   <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            pend_q  <= pend_d;
            ie_q    <= ie_d;
            cv_q    <= cv_d;
            cid_q   <= cid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = fire ? REQ : IDLE;
            REQ:     state_d = (bus.IntAck && fire) ? SERVICE : fire ? REQ : IDLE;
            SERVICE: state_d = bus.Eret ? IDLE : SERVICE;
            default: state_d = IDLE;
        endcase
    end

    // An ack with nothing active is spurious: it only invalidates CAUSE.
    always_comb begin
        bus.IntReq = state_q == REQ;
        cv_d       = ack_in_req ? fire : (exl && bus.Eret) ? 1'b0 : cv_q;
        cid_d      = (ack_in_req && fire) ? id : cid_q;
    end

    always_comb begin
        bus.Dataout = (bus.addr == REG_MASK)  ? 32'(mask_q) :
                      (bus.addr == REG_PEND)  ? 32'(pend_q) :
                      (bus.addr == REG_CAUSE) ? {cv_q, 28'd0, cid_q} :
                                                {30'd0, exl, ie_q};
    end
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: table-driven cycle vectors plus hand sequences for reset-in-SERVICE
// and source-to-request latency.
module tb_irq_ctrl;
    localparam logic [1:0] M = 2'd0, P = 2'd1, C = 2'd2, S = 2'd3;
`ifdef IRQ_EDGE_DETECT_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    typedef struct {
        logic        we;
        logic [1:0]  waddr;
        logic [31:0] din;
        logic [5:0]  hw;
        logic        ack;
        logic        eret;
        logic [1:0]  raddr;
        logic [31:0] exp_rd;
        logic        exp_req;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] hw;
    int         n_cmp = 0;
    int         n_bad = 0;
    vec_t       vecs[$];

    irq_ctrl_if bus();
    irq_ctrl #(.N_SRC(6)) dut (.clk(clk), .reset(reset), .HWInt(hw), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic we, input logic [1:0] wa, input logic [31:0] din,
                       input logic [5:0] h, input logic ack, input logic eret,
                       input logic [1:0] ra, input logic [31:0] exp, input logic req);
        vecs.push_back('{we, wa, din, h, ack, eret, ra, exp, req});
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.addr = a; bus.We = 1'b1; bus.Datain = d;
        @(posedge clk); #1;
        bus.We = 1'b0;
    endtask

    initial begin
        int lat;
        reset = 1'b1; hw = '0;
        bus.addr = '0; bus.We = 1'b0; bus.Datain = '0; bus.IntAck = 1'b0; bus.Eret = 1'b0;
        // basic request, ack, W1C, return
        add(1, M, 32'h01, 6'h00, 0, 0, M, 32'h01, 0);
        add(1, S, 32'h01, 6'h00, 0, 0, S, 32'h01, 0);
        add(0, M, 32'h00, 6'h01, 0, 0, P, 32'h01, 0);
        add(0, M, 32'h00, 6'h00, 0, 0, P, 32'h01, 1);
        add(0, M, 32'h00, 6'h00, 1, 0, C, 32'h8000_0000, 0);
        add(0, M, 32'h00, 6'h00, 0, 0, S, 32'h03, 0);
        add(1, P, 32'h01, 6'h00, 0, 0, P, 32'h00, 0);
        add(0, M, 32'h00, 6'h00, 0, 1, C, 32'h00, 0);
        add(0, M, 32'h00, 6'h00, 0, 0, S, 32'h01, 0);
        // two sources: priority, reassert after return
        add(1, M, 32'h3F, 6'h00, 0, 0, M, 32'h3F, 0);
        add(0, M, 32'h00, 6'h0A, 0, 0, P, 32'h0A, 0);
        add(0, M, 32'h00, 6'h00, 0, 0, P, 32'h0A, 1);
        add(0, M, 32'h00, 6'h00, 1, 0, C, 32'h8000_0001, 0);
        add(1, P, 32'h02, 6'h00, 0, 0, P, 32'h08, 0);
        add(0, M, 32'h00, 6'h00, 0, 1, C, 32'h01, 0);
        add(0, M, 32'h00, 6'h00, 0, 0, S, 32'h01, 1);
        add(0, M, 32'h00, 6'h00, 1, 0, C, 32'h8000_0003, 0);
        add(1, P, 32'h08, 6'h00, 0, 0, P, 32'h00, 0);
        add(0, M, 32'h00, 6'h00, 0, 1, S, 32'h01, 0);
        // masked source, unmask, re-mask while requesting
        add(1, M, 32'h3B, 6'h00, 0, 0, M, 32'h3B, 0);
        add(0, M, 32'h00, 6'h04, 0, 0, P, 32'h04, 0);
        add(0, M, 32'h00, 6'h00, 0, 0, P, 32'h04, 0);
        add(0, M, 32'h00, 6'h00, 0, 0, S, 32'h01, 0);
        add(1, M, 32'h3F, 6'h00, 0, 0, M, 32'h3F, 0);
        add(0, M, 32'h00, 6'h00, 0, 0, S, 32'h01, 1);
        add(1, M, 32'h3B, 6'h00, 0, 0, M, 32'h3B, 1);
        add(0, M, 32'h00, 6'h00, 0, 0, S, 32'h01, 0);
        add(1, P, 32'h04, 6'h00, 0, 0, P, 32'h00, 0);
        add(1, M, 32'h3F, 6'h00, 0, 0, M, 32'h3F, 0);
        // set beats W1C, clear during request, spurious ack, stray ack
        add(1, P, 32'h04, 6'h04, 0, 0, P, 32'h04, 0);
        add(0, M, 32'h00, 6'h00, 0, 0, P, 32'h04, 1);
        add(1, P, 32'h04, 6'h00, 0, 0, P, 32'h00, 1);
        add(0, M, 32'h00, 6'h00, 1, 0, S, 32'h01, 0);
        add(0, M, 32'h00, 6'h00, 0, 0, C, 32'h03, 0);
        add(0, M, 32'h00, 6'h00, 1, 0, S, 32'h01, 0);
        // held-high line versus W1C
        add(0, M, 32'h00, 6'h01, 0, 0, P, 32'h01, 0);
        add(1, P, 32'h01, 6'h01, 0, 0, P, EDGE ? 32'h00 : 32'h01, 1);
        add(1, P, 32'h01, 6'h00, 0, 0, P, 32'h00, !EDGE);
        add(0, M, 32'h00, 6'h00, 0, 0, P, 32'h00, 0);
        // enter SERVICE ahead of the reset sequence
        add(0, M, 32'h00, 6'h02, 0, 0, P, 32'h02, 0);
        add(0, M, 32'h00, 6'h00, 0, 0, P, 32'h02, 1);
        add(0, M, 32'h00, 6'h00, 1, 0, C, 32'h8000_0001, 0);

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int a = 0; a < 4; a++) begin
            bus.addr = 2'(a); #1;
            chk($sformatf("reset reg%0d", a), bus.Dataout, 32'h0);
        end
        chk("reset IntReq", {31'd0, bus.IntReq}, 32'h0);

        foreach (vecs[k]) begin
            bus.addr = vecs[k].waddr; bus.We = vecs[k].we; bus.Datain = vecs[k].din;
            bus.IntAck = vecs[k].ack; bus.Eret = vecs[k].eret; hw = vecs[k].hw;
            @(posedge clk); #1;
            bus.We = 1'b0; bus.IntAck = 1'b0; bus.Eret = 1'b0; bus.addr = vecs[k].raddr;
            #1;
            chk($sformatf("v%0d read", k), bus.Dataout, vecs[k].exp_rd);
            chk($sformatf("v%0d IntReq", k), {31'd0, bus.IntReq}, {31'd0, vecs[k].exp_req});
        end

        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int a = 0; a < 4; a++) begin
            bus.addr = 2'(a); #1;
            chk($sformatf("svc reset reg%0d", a), bus.Dataout, 32'h0);
        end
        chk("svc reset IntReq", {31'd0, bus.IntReq}, 32'h0);
        bus.Eret = 1'b1;
        @(posedge clk); #1;
        bus.Eret = 1'b0;
        bus.addr = S; #1;
        chk("eret after reset STATUS", bus.Dataout, 32'h0);
        bus.addr = C; #1;
        chk("eret after reset CAUSE", bus.Dataout, 32'h0);
        chk("eret after reset IntReq", {31'd0, bus.IntReq}, 32'h0);

        wr(M, 32'h20);
        wr(S, 32'h01);
        hw = 6'h20;
        lat = -1;
        for (int i = 1; i <= 8 && lat < 0; i++) begin
            @(posedge clk); #1;
            hw = '0;
            if (bus.IntReq) lat = i;
        end
        chk("hw5 latency", 32'(lat), 32'd2);
        bus.IntAck = 1'b1;
        @(posedge clk); #1;
        bus.IntAck = 1'b0;
        bus.addr = C; #1;
        chk("hw5 CAUSE", bus.Dataout, 32'h8000_0005);
        chk("hw5 IntReq after ack", {31'd0, bus.IntReq}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
